mac_feeder: RTL and testbench
=============================

Name: mac_feeder

Overview:
- Initiator-side sequencer for one integer MAC processing element (PE).
- Reads operand vectors A and B from two 1-cycle-latency BRAM read ports and streams them to the PE as contiguous valid beats.
- Waits for the PE's completion strobe and reports the dot product of this run.
- The PE accumulator cannot be cleared, so the feeder snapshots the PE output before each run and returns the difference.

Parameters:
- BITWIDTH, 32, operand/result width; must match the PE.
- VECTOR_SIZE, 16, maximum vector length.
- ADDR_WIDTH, 4, BRAM address width; 2^ADDR_WIDTH >= VECTOR_SIZE.
- PE_DELAY, 16, PE completion delay in cycles; must be >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  run request, sampled in IDLE only.
- len  in  ADDR_WIDTH+1  vector length, sampled with start.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  completion-timeout flag, valid with done.
- result  out  BITWIDTH  dot product of the last run.
- a_en, b_en  out  1  BRAM read enables.
- a_addr, b_addr  out  ADDR_WIDTH  BRAM read addresses.
- a_rdata, b_rdata  in  BITWIDTH  BRAM read data, valid 1 cycle after en.
- pe_ain, pe_bin  out  BITWIDTH  PE operands.
- pe_valid  out  1  PE operand strobe.
- pe_dout  in  BITWIDTH  PE accumulator value.
- pe_dvalid  in  1  PE completion strobe.

Behaviour:
- Reset (synchronous, active-high) values: state=IDLE; busy, done, error, a_en, b_en, pe_valid = 0; result, addresses, pe_ain, pe_bin = 0. Guard counter loads 2.
- Reset mid-run aborts the run; no done pulse is issued. The PE is not reset by this block.
- Guard counter: loads 2 whenever rst or pe_valid is high, otherwise decrements to 0.
  - start is ignored while guard != 0 or state != IDLE.
  - Purpose: absorb products still in flight in the PE before the next snapshot.
- States: IDLE -> BASE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - On accepted start: latch n = min(len, VECTOR_SIZE), go to BASE.
  - len = 0: go directly to DONE with result=0 and error=0; no BRAM reads, no pe_valid.
- BASE (1 cycle): base <= pe_dout; idx <= 0; go to ISSUE.
- ISSUE (n cycles):
  - a_en = b_en = 1; a_addr = b_addr = idx; idx increments each cycle.
  - Go to DRAIN after the cycle with idx = n-1.
- Operand pipe:
  - pe_valid is the registered a_en, so it is high for exactly n contiguous cycles, delayed 1 cycle from the enables.
  - pe_ain = a_rdata and pe_bin = b_rdata when pe_valid = 1, else 0.
- DRAIN:
  - Ignore pe_dvalid until pe_valid has deasserted.
  - On the first pe_dvalid after that: capture = pe_dout; go to DONE.
  - Multiple pe_dvalid pulses are harmless; only the first is used.
- DONE (1 cycle):
  - done=1.
  - result <= capture - base, wrapping modulo 2^BITWIDTH. Signed and unsigned interpretations agree.
  - Go to IDLE.
- result holds its value until the next DONE. error holds until the next accepted start.
- start asserted in the same cycle as done is ignored (state is not IDLE).
- Latency, len=n >= 1, with the standard PE:
  - start sampled at edge 0.
  - pe_valid high in cycles 3..n+2.
  - pe_dvalid in cycle n+2+PE_DELAY.
  - done in cycle n+3+PE_DELAY.

Optional Feature:
- Macro: MAC_FEEDER_TIMEOUT_EN.
- Defined:
  - DRAIN counts cycles after pe_valid deasserts.
  - If 2*PE_DELAY cycles pass with no pe_dvalid, go to DONE with error=1 and result=0.
- Undefined:
  - DRAIN waits indefinitely.
  - error is tied to 0.

Test Plan:
- Reset, then len=4, A={1,2,3,4}, B={5,6,7,8}, PE_DELAY=16 -> pe_valid high cycles 3..6; done in cycle 23; result=70; error=0.
- Back-to-back second run with A=B={1,1,1,1}, with the PE accumulator already at 70 -> result=4, not 74.
- len=0 -> done 2 cycles after start; result=0; pe_valid never asserted; a_en never asserted.
- len=31 with VECTOR_SIZE=16 -> exactly 16 reads at addresses 0..15; 16 pe_valid beats.
- start pulsed while busy, and start pulsed in the done cycle -> both ignored; a single run is observed.
- rst asserted in the middle of ISSUE -> all outputs reach reset values on the next edge; no done pulse. A new start is accepted only after the guard expires, and the new run returns the correct result.
- Timeout (MAC_FEEDER_TIMEOUT_EN defined) with pe_dvalid held 0 -> done 32 cycles after pe_valid falls; error=1; result=0.

Source files
------------

// File: rtl/mac_feeder.sv
// mac_feeder: streams A/B operand vectors from two BRAM read ports into a MAC PE and reports the per-run dot product.
// Define MAC_FEEDER_TIMEOUT_EN to add a completion timeout that raises error.
module mac_feeder #(
    parameter int BITWIDTH    = 32,
    parameter int VECTOR_SIZE = 16,
    parameter int ADDR_WIDTH  = 4,
    parameter int PE_DELAY    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [BITWIDTH-1:0]   result,
    output logic                  a_en,
    output logic                  b_en,
    output logic [ADDR_WIDTH-1:0] a_addr,
    output logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [BITWIDTH-1:0]   a_rdata,
    input  logic [BITWIDTH-1:0]   b_rdata,
    output logic [BITWIDTH-1:0]   pe_ain,
    output logic [BITWIDTH-1:0]   pe_bin,
    output logic                  pe_valid,
    input  logic [BITWIDTH-1:0]   pe_dout,
    input  logic                  pe_dvalid
);

    typedef enum logic [2:0] {
        IDLE,
        BASE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0]   MAX_LEN  = (ADDR_WIDTH+1)'(VECTOR_SIZE);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    if (PE_DELAY < 2 || VECTOR_SIZE > (1 << ADDR_WIDTH)) begin : g_param_check
        $error("mac_feeder: needs PE_DELAY >= 2 and VECTOR_SIZE <= 2**ADDR_WIDTH");
    end

    state_t                state;
    logic [1:0]            guard;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   last_idx;
    logic                  zero_len;
    logic [BITWIDTH-1:0]   base;
    logic [BITWIDTH-1:0]   capture;
    logic [ADDR_WIDTH:0]   len_clamped;
    logic [ADDR_WIDTH:0]   len_last;
    logic                  accept;
    logic                  pe_done;
    logic                  timed_out;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
        len_last    = len_clamped - LEN_ONE;
    end

    assign accept  = start && (state == IDLE) && (guard == 2'd0);
    // Completion strobes are only trusted once the last operand beat has left.
    assign pe_done = pe_dvalid && !pe_valid;

    assign a_en   = rd_en;
    assign b_en   = rd_en;
    assign a_addr = addr;
    assign b_addr = addr;
    assign pe_ain = pe_valid ? a_rdata : '0;
    assign pe_bin = pe_valid ? b_rdata : '0;

    // Keeps the next snapshot away from products still in flight inside the PE.
    always_ff @(posedge clk) begin
        if (rst || pe_valid) begin
            guard <= 2'd2;
        end else if (guard != 2'd0) begin
            guard <= guard - 2'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            pe_valid <= 1'b0;
            addr     <= '0;
            last_idx <= '0;
            zero_len <= 1'b0;
            base     <= '0;
            capture  <= '0;
            result   <= '0;
        end else begin
            done     <= 1'b0;
            pe_valid <= rd_en;
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_idx <= len_last;
                        zero_len <= (len == '0);
                        busy     <= 1'b1;
                        state    <= BASE;
                    end
                end
                BASE: begin
                    base <= pe_dout;
                    addr <= '0;
                    if (zero_len) begin
                        capture <= pe_dout;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        rd_en <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if ({1'b0, addr} == last_idx) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        addr <= addr + ADDR_ONE;
                    end
                end
                DRAIN: begin
                    if (pe_done) begin
                        capture <= pe_dout;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else if (timed_out) begin
                        capture <= base;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    result <= capture - base;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MAC_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(2 * PE_DELAY);
    localparam logic [TW-1:0] WAIT_LAST = TW'(2 * PE_DELAY - 1);
    localparam logic [TW-1:0] WAIT_ONE  = TW'(1);

    logic [TW-1:0] wait_cnt;

    assign timed_out = (state == DRAIN) && !pe_valid && !pe_dvalid && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            error    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (accept) begin
                error <= 1'b0;
            end else if (timed_out) begin
                error <= 1'b1;
            end
            if ((state == DRAIN) && !pe_valid) begin
                wait_cnt <= wait_cnt + WAIT_ONE;
            end else begin
                wait_cnt <= '0;
            end
        end
    end
`else
    assign timed_out = 1'b0;
    assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder with a 1-cycle BRAM model and an accumulating PE model (dvalid PE_DELAY after last beat).
`timescale 1ns/1ps
module tb_mac_feeder;

    localparam int BW = 32;
    localparam int VS = 16;
    localparam int AW = 4;
    localparam int PD = 16;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   len   = '0;
    logic          busy, done, error, a_en, b_en, pe_valid, pe_dvalid;
    logic [BW-1:0] result, a_rdata, b_rdata, pe_ain, pe_bin, pe_dout;
    logic [AW-1:0] a_addr, b_addr;

    logic [BW-1:0] mem_a [VS];
    logic [BW-1:0] mem_b [VS];
    logic [BW-1:0] acc     = '0;
    int            dcnt    = 0;
    logic          pe_mute = 1'b0;

    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            beats = 0, reads = 0, addr_bad = 0, dones = 0;
    int            rise_cyc = 0, fall_cyc = 0;
    logic          pv_q = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    int            t0 = 0;

    mac_feeder #(
        .BITWIDTH   (BW),
        .VECTOR_SIZE(VS),
        .ADDR_WIDTH (AW),
        .PE_DELAY   (PD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .result   (result),
        .a_en     (a_en),
        .b_en     (b_en),
        .a_addr   (a_addr),
        .b_addr   (b_addr),
        .a_rdata  (a_rdata),
        .b_rdata  (b_rdata),
        .pe_ain   (pe_ain),
        .pe_bin   (pe_bin),
        .pe_valid (pe_valid),
        .pe_dout  (pe_dout),
        .pe_dvalid(pe_dvalid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (a_en) a_rdata <= mem_a[a_addr];
        if (b_en) b_rdata <= mem_b[b_addr];
    end

    always @(posedge clk) begin
        if (pe_valid) begin
            acc  <= acc + pe_ain * pe_bin;
            dcnt <= PD;
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
        end
    end
    assign pe_dvalid = (dcnt == 1) && !pe_mute;
    assign pe_dout   = acc;

    always @(negedge clk) begin
        pv_q <= pe_valid;
        if (pe_valid) beats <= beats + 1;
        if (pe_valid && !pv_q) rise_cyc <= cyc;
        if (!pe_valid && pv_q) fall_cyc <= cyc;
        if (done) dones <= dones + 1;
        if (a_en) begin
            reads    <= reads + 1;
            exp_addr <= exp_addr + 1'b1;
            if (a_addr != exp_addr || b_addr != exp_addr || !b_en) addr_bad <= addr_bad + 1;
        end else begin
            exp_addr <= '0;
            if (b_en) addr_bad <= addr_bad + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic start_run(input logic [AW:0] l);
        start = 1'b1;
        len   = l;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, {63'd0, done === 1'b1}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, r0, ab0, d0;

        for (int i = 0; i < VS; i++) begin
            mem_a[i] = BW'(i);
            mem_b[i] = BW'(i);
        end
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = BW'(i + 1);
            mem_b[i] = BW'(i + 5);
        end

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_a_en", a_en, 0);
        check("rst_b_en", b_en, 0);
        check("rst_pe_valid", pe_valid, 0);
        check("rst_result", result, 0);
        check("rst_a_addr", a_addr, 0);
        check("rst_b_addr", b_addr, 0);
        check("rst_pe_ain", pe_ain, 0);
        check("rst_pe_bin", pe_bin, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Run 1: 1*5 + 2*6 + 3*7 + 4*8 = 70
        b0 = beats;
        start_run(5'd4);
        wait_done("t1_done_seen", 200);
        check("t1_done_cyc", cyc - t0, 23);
        check("t1_error", error, 0);
        @(negedge clk);
        check("t1_result", result, 70);
        check("t1_done_pulse", done, 0);
        check("t1_busy_after", busy, 0);
        check("t1_valid_rise", rise_cyc - t0, 3);
        check("t1_valid_fall", fall_cyc - t0, 7);
        check("t1_beats", beats - b0, 4);

        // Run 2: PE already holds 70; the difference must be 4
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = 1;
            mem_b[i] = 1;
        end
        start_run(5'd4);
        wait_done("t2_done_seen", 200);
        check("t2_done_cyc", cyc - t0, 23);
        @(negedge clk);
        check("t2_result", result, 4);

        // Zero-length run
        b0 = beats;
        r0 = reads;
        start_run(5'd0);
        wait_done("t3_done_seen", 50);
        check("t3_done_cyc", cyc - t0, 2);
        check("t3_error", error, 0);
        @(negedge clk);
        check("t3_result", result, 0);
        check("t3_busy_after", busy, 0);
        repeat (2) @(negedge clk);
        check("t3_beats", beats - b0, 0);
        check("t3_reads", reads - r0, 0);

        // len=31 clamps to 16; sum of i*i for i=0..15 is 1240
        for (int i = 0; i < VS; i++) begin
            mem_a[i] = BW'(i);
            mem_b[i] = BW'(i);
        end
        b0  = beats;
        r0  = reads;
        ab0 = addr_bad;
        start_run(5'd31);
        wait_done("t4_done_seen", 200);
        check("t4_done_cyc", cyc - t0, 35);
        @(negedge clk);
        check("t4_result", result, 1240);
        check("t4_reads", reads - r0, 16);
        check("t4_beats", beats - b0, 16);
        check("t4_addr_seq", addr_bad - ab0, 0);
        check("t4_valid_rise", rise_cyc - t0, 3);
        check("t4_valid_fall", fall_cyc - t0, 19);

        // Start while busy and in the done cycle: only one run; 3*5 + 4*6 = 39
        mem_a[0] = 3;
        mem_a[1] = 4;
        mem_b[0] = 5;
        mem_b[1] = 6;
        d0 = dones;
        start_run(5'd2);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5_done_seen", 200);
        check("t5_done_cyc", cyc - t0, 21);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_result", result, 39);
        repeat (30) @(negedge clk);
        check("t5_busy_idle", busy, 0);
        check("t5_single_done", dones - d0, 1);

        // Reset in the middle of ISSUE, then restart once the guard expires
        for (int i = 0; i < VS; i++) begin
            mem_a[i] = 1;
            mem_b[i] = 1;
        end
        d0 = dones;
        start_run(5'd8);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        len   = 5'd5;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_a_en", a_en, 0);
        check("t6_rst_b_en", b_en, 0);
        check("t6_rst_pe_valid", pe_valid, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_a_addr", a_addr, 0);
        check("t6_rst_pe_ain", pe_ain, 0);
        check("t6_rst_result", result, 0);
        @(negedge clk);
        check("t6_guard_hold1", busy, 0);
        @(negedge clk);
        check("t6_guard_hold2", busy, 0);
        t0 = cyc;
        @(negedge clk);
        check("t6_accept", busy, 1);
        start = 1'b0;
        wait_done("t6_done_seen", 200);
        check("t6_done_cyc", cyc - t0, 24);
        @(negedge clk);
        check("t6_result", result, 5);
        check("t6_single_done", dones - d0, 1);

`ifdef MAC_FEEDER_TIMEOUT_EN
        // PE never signals completion: timeout 32 cycles after pe_valid falls
        pe_mute = 1'b1;
        start_run(5'd2);
        wait_done("t7_done_seen", 200);
        check("t7_done_cyc", cyc - t0, 37);
        check("t7_error", error, 1);
        @(negedge clk);
        check("t7_valid_fall", fall_cyc - t0, 5);
        check("t7_result", result, 0);
        check("t7_error_hold", error, 1);
        pe_mute = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
